// File: rtl/filter_window_gen.sv
// Sliding WINxWIN window generator for raster-order pixel streams.
// Line buffers feed a column shift array; windows carry bottom-right pixel coordinates.
module filter_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WIN    = 3,
    localparam int ROW_W = $clog2(IMG_H),
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                      sclk,
    input  logic                      s_rst,
    input  logic                      vsync,
    input  logic [DATA_W-1:0]         din,
    input  logic                      din_valid,
    output logic [WIN*WIN*DATA_W-1:0] win_data,
    output logic                      win_valid,
    output logic [ROW_W-1:0]          win_row,
    output logic [COL_W-1:0]          win_col,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic [1:0]                dbg_state
);

    // din_valid qualifies din for one cycle (no back-pressure); win_valid is a
    // one-cycle pulse qualifying win_data/win_row/win_col in that same cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(WIN - 1);
    localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(WIN - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, cur_row;
    logic [COL_W-1:0]   col_q, col_d, cur_col;
    logic               frame_err_q, frame_err_d;
    logic               accept, last_px;

    // vsync restarts the frame in the same cycle, so a coincident pixel is (0,0).
    always_comb begin
        cur_row     = vsync ? '0 : row_q;
        cur_col     = vsync ? '0 : col_q;
        accept      = din_valid && !s_rst && (vsync || (state_q == ACTIVE));
        last_px     = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        state_d     = state_q;
        row_d       = cur_row;
        col_d       = cur_col;
        frame_err_d = frame_err_q;
        if (vsync) begin
            state_d     = ACTIVE;
            frame_err_d = 1'b0;
        end else if ((state_q == DONE) && din_valid) begin
            frame_err_d = 1'b1;
        end
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
        end
        if (last_px) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Line buffer k holds row r-1-k; each shifts its old entry into the next buffer.
    logic [DATA_W-1:0] lb_rd [WIN-1];

    for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
        logic [DATA_W-1:0] mem [IMG_W];
        assign lb_rd[k] = mem[cur_col];
        if (k == 0) begin : g_head
            always_ff @(posedge sclk) begin
                if (accept) mem[cur_col] <= din;
            end
        end else begin : g_chain
            always_ff @(posedge sclk) begin
                if (accept) mem[cur_col] <= lb_rd[k-1];
            end
        end
    end

    logic              s1_vld_q, s1_ok_q, s1_last_q;
    logic [DATA_W-1:0] s1_din_q;
    logic [DATA_W-1:0] s1_rd_q [WIN-1];
    logic [ROW_W-1:0]  s1_row_q;
    logic [COL_W-1:0]  s1_col_q;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            s1_vld_q  <= 1'b0;
            s1_ok_q   <= 1'b0;
            s1_last_q <= 1'b0;
            s1_din_q  <= '0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            for (int k = 0; k < WIN - 1; k++) s1_rd_q[k] <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_din_q  <= din;
                s1_row_q  <= cur_row;
                s1_col_q  <= cur_col;
                s1_ok_q   <= (cur_row >= ROW_WIN0) && (cur_col >= COL_WIN0);
                s1_last_q <= last_px;
                for (int k = 0; k < WIN - 1; k++) s1_rd_q[k] <= lb_rd[k];
            end
        end
    end

    // Column array indexed [j][i]: j=0 leftmost column, i=0 oldest row.
    logic [WIN-1:0][DATA_W-1:0] col_arr_q [WIN];
    logic [WIN-1:0][DATA_W-1:0] new_col;
    logic                       s2_vld_q, s2_last_q;
    logic [ROW_W-1:0]           s2_row_q;
    logic [COL_W-1:0]           s2_col_q;

    always_comb begin
        new_col        = '0;
        new_col[WIN-1] = s1_din_q;
        for (int k = 0; k < WIN - 1; k++) new_col[WIN-2-k] = s1_rd_q[k];
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            for (int j = 0; j < WIN; j++) col_arr_q[j] <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_row_q  <= '0;
            s2_col_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q && s1_ok_q;
            if (s1_vld_q) begin
                for (int j = 0; j < WIN - 1; j++) col_arr_q[j] <= col_arr_q[j+1];
                col_arr_q[WIN-1] <= new_col;
                s2_row_q  <= s1_row_q;
                s2_col_q  <= s1_col_q;
                s2_last_q <= s1_last_q;
            end
        end
    end

    logic [WIN*WIN*DATA_W-1:0] win_d, win_data_q;
    logic                      win_valid_q, out_last_q, frame_done_q;
    logic [ROW_W-1:0]          win_row_q;
    logic [COL_W-1:0]          win_col_q;

    always_comb begin
        win_d = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                win_d[(i*WIN+j)*DATA_W +: DATA_W] = col_arr_q[j][i];
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= s2_vld_q;
            out_last_q   <= s2_vld_q && s2_last_q;
            frame_done_q <= out_last_q;
            if (s2_vld_q) begin
                win_data_q <= win_d;
                win_row_q  <= s2_row_q;
                win_col_q  <= s2_col_q;
            end
        end
    end

    assign win_data   = win_data_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_filter_window_gen.sv
// Bench for filter_window_gen: 8x6 frames into a WIN=3 and a WIN=5 instance,
// scoreboarded against a frame-image reference model plus directed window tables.
module tb_filter_window_gen;

    localparam int IW    = 8;
    localparam int IH    = 6;
    localparam int TOTAL = IW * IH;

    logic         sclk, s_rst, vsync, din_valid;
    logic [7:0]   din;
    logic [71:0]  wd3;
    logic [199:0] wd5;
    logic         wv3, wv5, fd3, fd5, fe3, fe5;
    logic [2:0]   wr3, wc3, wr5, wc5;
    logic [1:0]   st3, st5;

    filter_window_gen #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH), .WIN(3)) u_dut3 (
        .sclk(sclk), .s_rst(s_rst), .vsync(vsync), .din(din), .din_valid(din_valid),
        .win_data(wd3), .win_valid(wv3), .win_row(wr3), .win_col(wc3),
        .frame_done(fd3), .frame_err(fe3), .dbg_state(st3)
    );

    filter_window_gen #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH), .WIN(5)) u_dut5 (
        .sclk(sclk), .s_rst(s_rst), .vsync(vsync), .din(din), .din_valid(din_valid),
        .win_data(wd5), .win_valid(wv5), .win_row(wr5), .win_col(wc5),
        .frame_done(fd5), .frame_err(fe5), .dbg_state(st5)
    );

    typedef struct {
        int           w;
        logic [199:0] data;
        int           row;
        int           col;
        int           due;
    } win_t;

    typedef struct {
        int          idx;
        int          row;
        int          col;
        logic [71:0] data;
    } vec_t;

    win_t       exp_q[$];
    int         done_q[$];
    win_t       log3[$];
    win_t       log5[$];
    vec_t       vecs[5];
    logic [7:0] img [IH][IW];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt3 = 0;
    int         done_cnt5 = 0;
    bit         have_frame = 0;
    int         npx = 0;
    bit         exp_err = 0;

    // clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: frame image filled in raster order since the last vsync
    task automatic accept_px(input logic [7:0] d);
        int r;
        int c;
        r = npx / IW;
        c = npx % IW;
        img[r][c] = d;
        npx++;
        for (int wi = 0; wi < 2; wi++) begin
            int w = (wi == 0) ? 3 : 5;
            if (r >= w - 1 && c >= w - 1) begin
                win_t e;
                e.w = w;
                e.data = '0;
                for (int i = 0; i < w; i++)
                    for (int j = 0; j < w; j++)
                        e.data[(i*w+j)*8 +: 8] = img[r-w+1+i][c-w+1+j];
                e.row = r;
                e.col = c;
                e.due = cyc + 2;
                exp_q.push_back(e);
            end
        end
        if (npx == TOTAL) done_q.push_back(cyc + 3);
    endtask

    always @(posedge sclk) begin
        cyc++;
        if (s_rst) begin
            have_frame = 0;
            npx = 0;
            exp_err = 0;
            exp_q.delete();
            done_q.delete();
        end else begin
            if (vsync) begin
                have_frame = 1;
                npx = 0;
                exp_err = 0;
            end
            if (din_valid && have_frame) begin
                if (npx < TOTAL) accept_px(din);
                else exp_err = 1;
            end
        end
    end

    // scoreboard
    task automatic mon_win(input int w, input logic v, input logic [199:0] d,
                           input logic [2:0] row, input logic [2:0] col);
        int   k;
        logic ev;
        k = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].w == w) begin
                k = i;
                break;
            end
        end
        ev = (k >= 0) && (exp_q[k].due == cyc);
        chk($sformatf("win_valid%0d", w), v, ev);
        if (v && ev) begin
            chk($sformatf("win_data%0d", w), d, exp_q[k].data);
            chk($sformatf("win_row%0d", w), row, exp_q[k].row);
            chk($sformatf("win_col%0d", w), col, exp_q[k].col);
        end
        if (ev) exp_q.delete(k);
        if (v) begin
            win_t o;
            o.w = w; o.data = d; o.row = row; o.col = col; o.due = cyc;
            if (w == 3) log3.push_back(o);
            else log5.push_back(o);
        end
    endtask

    always @(negedge sclk) begin
        logic ed;
        mon_win(3, wv3, {128'b0, wd3}, wr3, wc3);
        mon_win(5, wv5, wd5, wr5, wc5);
        ed = (done_q.size() > 0) && (done_q[0] == cyc);
        if (ed) void'(done_q.pop_front());
        chk("frame_done3", fd3, ed);
        chk("frame_done5", fd5, ed);
        chk("frame_err3", fe3, exp_err);
        chk("frame_err5", fe5, exp_err);
        if (fd3) done_cnt3++;
        if (fd5) done_cnt5++;
    end

    // driver tasks
    task automatic cycle(input logic v, input logic dv, input logic [7:0] d);
        vsync = v;
        din_valid = dv;
        din = d;
        @(posedge sclk);
        #1;
        vsync = 1'b0;
        din_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int n);
        return 8'((n / IW) * 16 + (n % IW));
    endfunction

    // vs_mode: 0 no vsync, 1 separate vsync cycle first, 2 vsync on the first pixel
    task automatic send_range(input int from, input int to, input int gap,
                              input int vs_mode, input logic [7:0] xv);
        if (vs_mode == 1) cycle(1'b1, 1'b0, 8'h00);
        for (int n = from; n <= to; n++) begin
            cycle(vs_mode == 2 && n == from, 1'b1, pat(n) ^ xv);
            repeat (gap) cycle(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_logs();
        log3.delete();
        log5.delete();
        done_cnt3 = 0;
        done_cnt5 = 0;
    endtask

    task automatic check_table(input string tag);
        chk({tag, " n_win3"}, log3.size(), 24);
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].idx < log3.size()) begin
                chk($sformatf("%s row[%0d]", tag, vecs[v].idx), log3[vecs[v].idx].row, vecs[v].row);
                chk($sformatf("%s col[%0d]", tag, vecs[v].idx), log3[vecs[v].idx].col, vecs[v].col);
                chk($sformatf("%s data[%0d]", tag, vecs[v].idx), log3[vecs[v].idx].data, {128'b0, vecs[v].data});
            end
        end
        chk({tag, " n_win5"}, log5.size(), 8);
        if (log5.size() > 0) begin
            chk({tag, " w5 row0"}, log5[0].row, 4);
            chk({tag, " w5 col0"}, log5[0].col, 4);
            chk({tag, " w5 e00"}, log5[0].data[7:0], 8'h00);
            chk({tag, " w5 e44"}, log5[0].data[199:192], 8'h44);
        end
        chk({tag, " done3"}, done_cnt3, 1);
        chk({tag, " done5"}, done_cnt5, 1);
    endtask

    initial begin
        vecs[0] = '{0,  2, 2, 72'h22_21_20_12_11_10_02_01_00};
        vecs[1] = '{5,  2, 7, 72'h27_26_25_17_16_15_07_06_05};
        vecs[2] = '{6,  3, 2, 72'h32_31_30_22_21_20_12_11_10};
        vecs[3] = '{17, 4, 7, 72'h47_46_45_37_36_35_27_26_25};
        vecs[4] = '{23, 5, 7, 72'h57_56_55_47_46_45_37_36_35};

        s_rst = 1'b1;
        vsync = 1'b0;
        din_valid = 1'b0;
        din = 8'h00;
        idle(3);
        chk("rst win_data3", wd3, 0);
        chk("rst win_valid3", wv3, 0);
        chk("rst win_row3", wr3, 0);
        chk("rst win_col3", wc3, 0);
        chk("rst frame_done3", fd3, 0);
        chk("rst frame_err3", fe3, 0);
        chk("rst win_data5", wd5, 0);
        chk("rst win_valid5", wv5, 0);
        s_rst = 1'b0;

        // pixels in IDLE are ignored
        clear_logs();
        send_range(0, 20, 0, 0, 8'h00);
        idle(4);
        chk("idle n_win3", log3.size(), 0);
        chk("idle frame_err3", fe3, 0);

        // full frame, continuous valid
        clear_logs();
        send_range(0, TOTAL - 1, 0, 1, 8'h00);
        idle(6);
        check_table("cont");

        // same frame, one pixel every third cycle
        clear_logs();
        send_range(0, TOTAL - 1, 2, 1, 8'h00);
        idle(6);
        check_table("gap");

        // vsync at pixel (3,5) abandons frame 1
        clear_logs();
        send_range(0, 28, 0, 1, 8'h80);
        send_range(0, TOTAL - 1, 0, 2, 8'h00);
        idle(6);
        chk("abort n_win3", log3.size(), 33);
        chk("abort done3", done_cnt3, 1);
        if (log3.size() > 9) begin
            chk("abort first row", log3[9].row, 2);
            chk("abort first data", log3[9].data, {128'b0, vecs[0].data});
        end

        // vsync coinciding with the final pixel: that pixel starts the next frame
        clear_logs();
        send_range(0, TOTAL - 2, 0, 1, 8'h40);
        send_range(0, TOTAL - 1, 0, 2, 8'h00);
        idle(6);
        chk("vs_last n_win3", log3.size(), 47);
        chk("vs_last done3", done_cnt3, 1);

        // extra pixels after the frame completes
        clear_logs();
        send_range(0, 2, 0, 0, 8'h33);
        idle(3);
        chk("extra frame_err3", fe3, 1);
        chk("extra frame_err5", fe5, 1);
        chk("extra n_win3", log3.size(), 0);
        cycle(1'b1, 1'b0, 8'h00);
        chk("vsync clears frame_err3", fe3, 0);

        // reset at pixel (2,4)
        clear_logs();
        send_range(0, 19, 0, 0, 8'h00);
        s_rst = 1'b1;
        cycle(1'b0, 1'b1, pat(20));
        s_rst = 1'b0;
        chk("mid rst win_valid3", wv3, 0);
        chk("mid rst win_data3", wd3, 0);
        chk("mid rst win_row3", wr3, 0);
        chk("mid rst win_col3", wc3, 0);
        chk("mid rst frame_done3", fd3, 0);
        send_range(21, TOTAL - 1, 0, 0, 8'h00);
        idle(6);
        chk("post rst n_win3", log3.size(), 0);
        chk("post rst n_win5", log5.size(), 0);
        chk("post rst done3", done_cnt3, 0);

        // randomized frames: gaps, aborts, vsync-on-pixel, trailing extra pixels
        for (int f = 0; f < 10; f++) begin
            int abort_at;
            int vsf;
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, TOTAL - 1)) : TOTAL;
            vsf = int'($urandom_range(0, 1));
            if (vsf == 0) cycle(1'b1, 1'b0, 8'h00);
            for (int n = 0; n < abort_at; n++) begin
                cycle(vsf == 1 && n == 0, 1'b1, 8'($urandom));
                repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 8'h00);
            end
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b1, 8'($urandom));
            idle(int'($urandom_range(0, 4)));
        end

        idle(8);
        chk("drain exp_q", exp_q.size(), 0);
        chk("drain done_q", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
